// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle shared by the demux stage and its neighbours.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. Once tvalid is raised the master holds it and every payload
// field constant until that transfer happens; tready may change freely and
// the master never waits for tready before raising tvalid.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/logic_axi4_stream_demux_stage.sv
// Packet-aware 1-to-OUTPUTS AXI4-Stream demultiplexer.
// One input register (s0) feeds one output register per tx port. The head
// beat's tdest picks the port; the lock FSM holds that choice for the rest of
// the packet. Packets aimed at a nonexistent port are swallowed at one beat
// per cycle and reported on dropped. lock_state shows the FSM (1 = LOCKED).
module logic_axi4_stream_demux_stage #(
  parameter int OUTPUTS     = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1
) (
  input  logic                aclk,
  input  logic                areset,
  logic_axi4_stream_if.slave  rx,
  logic_axi4_stream_if.master tx [OUTPUTS],
  output logic                dropped,
  output logic                lock_state
);
  localparam int SEL_W  = $clog2(OUTPUTS);
  localparam int DATA_W = TDATA_BYTES * 8;
  // OUTPUTS <= 2**TDEST_WIDTH, so one extra bit always holds the port count.
  localparam logic [TDEST_WIDTH:0] OUT_N = (TDEST_WIDTH + 1)'(OUTPUTS);

  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} lock_t;

  // Stage 0 register; disabled fields are normalised on capture.
  logic                   s0_valid;
  logic [DATA_W-1:0]      s0_data;
  logic [TDATA_BYTES-1:0] s0_keep, s0_strb;
  logic                   s0_last;
  logic [TID_WIDTH-1:0]   s0_id;
  logic [TDEST_WIDTH-1:0] s0_dest;
  logic [TUSER_WIDTH-1:0] s0_user;

  // Output registers.
  logic [OUTPUTS-1:0]     out_valid, out_ready, load;
  logic [DATA_W-1:0]      out_data [OUTPUTS];
  logic [TDATA_BYTES-1:0] out_keep [OUTPUTS];
  logic [TDATA_BYTES-1:0] out_strb [OUTPUTS];
  logic [OUTPUTS-1:0]     out_last;
  logic [TID_WIDTH-1:0]   out_id   [OUTPUTS];
  logic [TDEST_WIDTH-1:0] out_dest [OUTPUTS];
  logic [TUSER_WIDTH-1:0] out_user [OUTPUTS];

  lock_t            state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel;
  logic             drop_q, drop_d;
  logic             locked, route_ok, s0_leave, rx_ready, dropped_q;

  // Route decision: body beats follow the latched route, heads use tdest.
  assign locked   = (state_q == LOCKED);
  assign sel      = locked ? sel_q : s0_dest[SEL_W-1:0];
  assign route_ok = locked ? !drop_q : ({1'b0, s0_dest} < OUT_N);
  assign s0_leave = s0_valid && (!route_ok || !out_valid[sel] || out_ready[sel]);
  assign rx_ready = !areset && (!s0_valid || s0_leave);
  assign rx.tready = rx_ready;

  // Stage 0: refill whenever the held beat leaves or the register is empty.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s0_valid <= 1'b0;
    end else if (rx.tvalid && rx_ready) begin
      s0_valid <= 1'b1;
      s0_data  <= rx.tdata;
      s0_keep  <= (USE_TKEEP != 0) ? rx.tkeep : '1;
      s0_strb  <= (USE_TSTRB != 0) ? rx.tstrb : '1;
      s0_last  <= (USE_TLAST != 0) ? rx.tlast : 1'b1;
      s0_id    <= rx.tid;
      s0_dest  <= rx.tdest;
      s0_user  <= rx.tuser;
    end else if (s0_leave) begin
      s0_valid <= 1'b0;
    end
  end

  // One-hot load strobe for the output register the leaving beat targets.
  always_comb begin
    load = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      load[i] = s0_leave && route_ok && (sel == SEL_W'(i));
    end
  end

  // Output registers: a reload wins over a drain so tvalid stays high.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < OUTPUTS; i++) begin
      if (load[i]) begin
        out_valid[i] <= 1'b1;
        out_data[i]  <= s0_data;
        out_keep[i]  <= s0_keep;
        out_strb[i]  <= s0_strb;
        out_last[i]  <= s0_last;
        out_id[i]    <= s0_id;
        out_dest[i]  <= s0_dest;
        out_user[i]  <= s0_user;
      end else if (out_ready[i]) begin
        out_valid[i] <= 1'b0;
      end
      if (areset) begin
        out_valid[i] <= 1'b0;
      end
    end
  end

  // Lock FSM state, latched route and the discard pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= OPEN;
      sel_q     <= '0;
      drop_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      drop_q    <= drop_d;
      dropped_q <= s0_leave && !route_ok && s0_last;
    end
  end

  // Lock FSM next state: a head without tlast locks, the tlast beat unlocks.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    drop_d  = drop_q;
    case (state_q)
      OPEN: begin
        if (s0_leave && !s0_last) begin
          state_d = LOCKED;
          sel_d   = sel;
          drop_d  = !route_ok;
        end
      end
      LOCKED: begin
        if (s0_leave && s0_last) begin
          state_d = OPEN;
        end
      end
      default: state_d = OPEN;
    endcase
  end

  assign dropped    = dropped_q;
  assign lock_state = locked;

  // Drive each tx port straight from its output register.
  for (genvar g = 0; g < OUTPUTS; g++) begin : g_tx
    assign tx[g].tvalid = out_valid[g];
    assign tx[g].tdata  = out_data[g];
    assign tx[g].tkeep  = out_keep[g];
    assign tx[g].tstrb  = out_strb[g];
    assign tx[g].tlast  = out_last[g];
    assign tx[g].tid    = out_id[g];
    assign tx[g].tdest  = out_dest[g];
    assign tx[g].tuser  = out_user[g];
    assign out_ready[g] = tx[g].tready;
  end
endmodule

// File: tb/tb_logic_axi4_stream_demux_stage.sv
// Bench for logic_axi4_stream_demux_stage.
// Three instances share one rx stimulus; sel_dut picks the one being checked:
//   A: OUTPUTS=4, TDEST_WIDTH=3 (routing, lock, backpressure, reset, tdest=4 drop)
//   B: OUTPUTS=3, TDEST_WIDTH=2 (tdest=3 drop)
//   C: OUTPUTS=2, USE_TLAST=0   (independent beats at full rate)
// Inputs change #1 after a rising edge; outputs are sampled on falling edges.
module tb_logic_axi4_stream_demux_stage;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = '0;
  logic [2:0] rx_dest  = '0;
  logic       rx_last  = 1'b0;
  int         sel_dut  = 0;

  logic [3:0] a_rdy = '1;
  logic [2:0] b_rdy = '1;
  logic [1:0] c_rdy = '1;
  logic [3:0] a_v, a_l;
  logic [2:0] b_v, b_l;
  logic [1:0] c_v, c_l;
  logic [7:0] a_d [4];
  logic [7:0] b_d [3];
  logic [7:0] c_d [2];
  logic a_rxr, b_rxr, c_rxr, a_drop, b_drop, c_drop, a_lk, b_lk, c_lk;

  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(3), .TUSER_WIDTH(1), .TID_WIDTH(1)) a_rx ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(3), .TUSER_WIDTH(1), .TID_WIDTH(1)) a_tx [4] ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) b_rx ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) b_tx [3] ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1)) c_rx ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1)) c_tx [2] ();

  assign a_rx.tvalid = rx_valid;  assign b_rx.tvalid = rx_valid;  assign c_rx.tvalid = rx_valid;
  assign a_rx.tdata  = rx_data;   assign b_rx.tdata  = rx_data;   assign c_rx.tdata  = rx_data;
  assign a_rx.tlast  = rx_last;   assign b_rx.tlast  = rx_last;   assign c_rx.tlast  = rx_last;
  assign a_rx.tdest  = rx_dest;   assign b_rx.tdest  = rx_dest[1:0]; assign c_rx.tdest = rx_dest[0];
  assign a_rx.tkeep  = 1'b1;      assign b_rx.tkeep  = 1'b1;      assign c_rx.tkeep  = 1'b1;
  assign a_rx.tstrb  = 1'b1;      assign b_rx.tstrb  = 1'b1;      assign c_rx.tstrb  = 1'b1;
  assign a_rx.tid    = 1'b0;      assign b_rx.tid    = 1'b0;      assign c_rx.tid    = 1'b0;
  assign a_rx.tuser  = 1'b0;      assign b_rx.tuser  = 1'b0;      assign c_rx.tuser  = 1'b0;
  assign a_rxr = a_rx.tready;     assign b_rxr = b_rx.tready;     assign c_rxr = c_rx.tready;

  for (genvar g = 0; g < 4; g++) begin : g_a
    assign a_tx[g].tready = a_rdy[g];
    assign a_v[g] = a_tx[g].tvalid;
    assign a_d[g] = a_tx[g].tdata;
    assign a_l[g] = a_tx[g].tlast;
  end
  for (genvar g = 0; g < 3; g++) begin : g_b
    assign b_tx[g].tready = b_rdy[g];
    assign b_v[g] = b_tx[g].tvalid;
    assign b_d[g] = b_tx[g].tdata;
    assign b_l[g] = b_tx[g].tlast;
  end
  for (genvar g = 0; g < 2; g++) begin : g_c
    assign c_tx[g].tready = c_rdy[g];
    assign c_v[g] = c_tx[g].tvalid;
    assign c_d[g] = c_tx[g].tdata;
    assign c_l[g] = c_tx[g].tlast;
  end

  logic_axi4_stream_demux_stage #(.OUTPUTS(4), .TDATA_BYTES(1), .TDEST_WIDTH(3), .TUSER_WIDTH(1),
    .TID_WIDTH(1), .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)) dut_a (
    .aclk(aclk), .areset(areset), .rx(a_rx), .tx(a_tx), .dropped(a_drop), .lock_state(a_lk));
  logic_axi4_stream_demux_stage #(.OUTPUTS(3), .TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1),
    .TID_WIDTH(1), .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)) dut_b (
    .aclk(aclk), .areset(areset), .rx(b_rx), .tx(b_tx), .dropped(b_drop), .lock_state(b_lk));
  logic_axi4_stream_demux_stage #(.OUTPUTS(2), .TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
    .TID_WIDTH(1), .USE_TLAST(0), .USE_TKEEP(0), .USE_TSTRB(0)) dut_c (
    .aclk(aclk), .areset(areset), .rx(c_rx), .tx(c_tx), .dropped(c_drop), .lock_state(c_lk));

  // rx.tready of the instance under test.
  logic rx_ready_sel;
  always_comb begin
    rx_ready_sel = a_rxr;
    if (sel_dut == 1) rx_ready_sel = b_rxr;
    if (sel_dut == 2) rx_ready_sel = c_rxr;
  end

  // Scoreboard: entries are {port[3:0], tlast, tdata[7:0]}.
  logic [12:0] exp_q [$];
  logic [12:0] got_q [$];
  int          got_t [$];
  int cyc = 0, acc_cnt = 0, drop_cnt = 0, stall_cnt = 0;
  int errors = 0, checks = 0;

  // Monitor: on each falling edge log the transfers the next rising edge completes.
  always @(negedge aclk) begin
    cyc++;
    case (sel_dut)
      0: begin
        if (rx_valid && a_rxr) acc_cnt++;
        if (a_drop) drop_cnt++;
        for (int i = 0; i < 4; i++)
          if (a_v[i] && a_rdy[i]) begin got_q.push_back({4'(i), a_l[i], a_d[i]}); got_t.push_back(cyc); end
      end
      1: begin
        if (rx_valid && b_rxr) acc_cnt++;
        if (b_drop) drop_cnt++;
        for (int i = 0; i < 3; i++)
          if (b_v[i] && b_rdy[i]) begin got_q.push_back({4'(i), b_l[i], b_d[i]}); got_t.push_back(cyc); end
      end
      default: begin
        if (rx_valid && c_rxr) acc_cnt++;
        if (c_drop) drop_cnt++;
        for (int i = 0; i < 2; i++)
          if (c_v[i] && c_rdy[i]) begin got_q.push_back({4'(i), c_l[i], c_d[i]}); got_t.push_back(cyc); end
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_sb(input string tag);
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Called and returns at posedge+#1; holds the beat until rx.tready is seen.
  task automatic send(input logic [7:0] d, input logic [2:0] dest, input logic last);
    rx_valid = 1'b1; rx_data = d; rx_dest = dest; rx_last = last;
    for (int n = 0; n < 64; n++) begin
      @(negedge aclk);
      if (rx_ready_sel) begin
        @(posedge aclk); #1;
        return;
      end
      stall_cnt++;
      @(posedge aclk); #1;
    end
    chk($sformatf("send_timeout_%0h", d), 32'(0), 32'(1));
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic do_reset(input int d);
    @(posedge aclk); #1;
    sel_dut = d; areset = 1'b1; rx_valid = 1'b0;
    a_rdy = '1; b_rdy = '1; c_rdy = '1;
    @(posedge aclk); #1;
    areset = 1'b0;
    got_q.delete(); got_t.delete(); exp_q.delete();
    acc_cnt = 0; drop_cnt = 0; stall_cnt = 0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] dest;
    logic       l;
    logic       e_rdy;
    logic [3:0] e_mask;
    logic [7:0] e_d;
    logic       e_l;
    logic       e_drop;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic [2:0] dest, logic l, logic e_rdy,
                              logic [3:0] e_mask, logic [7:0] e_d, logic e_l, logic e_drop);
    vec_t r;
    r.v = v; r.d = d; r.dest = dest; r.l = l; r.e_rdy = e_rdy;
    r.e_mask = e_mask; r.e_d = e_d; r.e_l = e_l; r.e_drop = e_drop;
    return r;
  endfunction

  vec_t vt [16];

  initial begin
    // Per-cycle vectors on instance A, all tready = 1. Row n drives cycle n;
    // expectations are the registered outputs visible in that same cycle.
    vt[0]  = mk(1, 8'h11, 3'd2, 0, 1, 4'b0000, 8'h00, 0, 0);
    vt[1]  = mk(1, 8'h22, 3'd2, 0, 1, 4'b0000, 8'h00, 0, 0);
    vt[2]  = mk(1, 8'h33, 3'd2, 1, 1, 4'b0100, 8'h11, 0, 0);
    vt[3]  = mk(0, 8'h00, 3'd0, 0, 1, 4'b0100, 8'h22, 0, 0);
    vt[4]  = mk(0, 8'h00, 3'd0, 0, 1, 4'b0100, 8'h33, 1, 0);
    vt[5]  = mk(1, 8'hA1, 3'd1, 0, 1, 4'b0000, 8'h00, 0, 0);
    vt[6]  = mk(1, 8'hA2, 3'd3, 0, 1, 4'b0000, 8'h00, 0, 0);
    vt[7]  = mk(1, 8'hA3, 3'd3, 1, 1, 4'b0010, 8'hA1, 0, 0);
    vt[8]  = mk(1, 8'hB1, 3'd3, 1, 1, 4'b0010, 8'hA2, 0, 0);
    vt[9]  = mk(0, 8'h00, 3'd0, 0, 1, 4'b0010, 8'hA3, 1, 0);
    vt[10] = mk(0, 8'h00, 3'd0, 0, 1, 4'b1000, 8'hB1, 1, 0);
    vt[11] = mk(1, 8'hC1, 3'd4, 0, 1, 4'b0000, 8'h00, 0, 0);
    vt[12] = mk(1, 8'hC2, 3'd0, 1, 1, 4'b0000, 8'h00, 0, 0);
    vt[13] = mk(0, 8'h00, 3'd0, 0, 1, 4'b0000, 8'h00, 0, 0);
    vt[14] = mk(0, 8'h00, 3'd0, 0, 1, 4'b0000, 8'h00, 0, 1);
    vt[15] = mk(0, 8'h00, 3'd0, 0, 1, 4'b0000, 8'h00, 0, 0);

    // Reset values, during reset and on the first cycle after it.
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("reset_rx_ready", 32'(a_rxr), 32'(0));
    chk("reset_tvalid", 32'(a_v), 32'(0));
    chk("reset_dropped", 32'(a_drop), 32'(0));
    chk("reset_lock_open", 32'(a_lk), 32'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("post_reset_tvalid", 32'(a_v), 32'(0));
    chk("post_reset_rx_ready", 32'(a_rxr), 32'(1));
    chk("post_reset_dropped", 32'(a_drop), 32'(0));

    // Routing, lock and tdest=4 discard (full-width compare) from the table.
    for (int r = 0; r < 16; r++) begin
      @(posedge aclk); #1;
      rx_valid = vt[r].v; rx_data = vt[r].d; rx_dest = vt[r].dest; rx_last = vt[r].l;
      @(negedge aclk);
      chk($sformatf("vec%0d_rx_ready", r), 32'(a_rxr), 32'(vt[r].e_rdy));
      chk($sformatf("vec%0d_tvalid", r), 32'(a_v), 32'(vt[r].e_mask));
      chk($sformatf("vec%0d_dropped", r), 32'(a_drop), 32'(vt[r].e_drop));
      for (int k = 0; k < 4; k++)
        if (vt[r].e_mask[k]) begin
          chk($sformatf("vec%0d_tdata", r), 32'(a_d[k]), 32'(vt[r].e_d));
          chk($sformatf("vec%0d_tlast", r), 32'(a_l[k]), 32'(vt[r].e_l));
        end
    end

    // Backpressure: tx[0] stalled, only s0 and the output register fill.
    do_reset(0);
    a_rdy[0] = 1'b0;
    send(8'h40, 3'd0, 1'b0);
    send(8'h41, 3'd0, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h42; rx_dest = 3'd0; rx_last = 1'b0;
    stall_cnt = 0;
    repeat (4) begin
      @(negedge aclk);
      if (rx_ready_sel) stall_cnt++;
      @(posedge aclk); #1;
    end
    chk("bp_rx_ready_low", 32'(stall_cnt), 32'(0));
    chk("bp_accepted", 32'(acc_cnt), 32'(2));
    a_rdy[0] = 1'b1;
    send(8'h42, 3'd0, 1'b0);
    send(8'h43, 3'd0, 1'b1);
    idle(8);
    exp_q.push_back({4'd0, 1'b0, 8'h40});
    exp_q.push_back({4'd0, 1'b0, 8'h41});
    exp_q.push_back({4'd0, 1'b0, 8'h42});
    exp_q.push_back({4'd0, 1'b1, 8'h43});
    compare_sb("bp");

    // Reset in the middle of a packet locked to tx[1].
    do_reset(0);
    a_rdy[1] = 1'b0;
    send(8'h50, 3'd1, 1'b0);
    send(8'h51, 3'd1, 1'b0);
    rx_data = 8'h52; areset = 1'b1;
    @(negedge aclk);
    chk("midrst_rx_ready", 32'(a_rxr), 32'(0));
    @(posedge aclk); #1;
    areset = 1'b0; rx_valid = 1'b0; a_rdy[1] = 1'b1;
    @(negedge aclk);
    chk("midrst_tvalid", 32'(a_v), 32'(0));
    chk("midrst_lock_open", 32'(a_lk), 32'(0));
    chk("midrst_rx_ready_after", 32'(a_rxr), 32'(1));
    @(posedge aclk); #1;
    send(8'h60, 3'd0, 1'b1);
    idle(6);
    exp_q.push_back({4'd0, 1'b1, 8'h60});
    compare_sb("midrst");

    // Discard on instance B: tdest=3 with three outputs.
    do_reset(1);
    send(8'h70, 3'd3, 1'b0);
    send(8'h71, 3'd3, 1'b1);
    send(8'h72, 3'd0, 1'b1);
    idle(8);
    chk("inv_no_stall", 32'(stall_cnt), 32'(0));
    chk("inv_accepted", 32'(acc_cnt), 32'(3));
    chk("inv_dropped_pulses", 32'(drop_cnt), 32'(1));
    exp_q.push_back({4'd0, 1'b1, 8'h72});
    compare_sb("inv");

    // Full-rate stream on instance C, no tlast: every beat is its own packet.
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      send(8'h80 + 8'(i), 3'(i % 2), 1'b0);
      exp_q.push_back({4'(i % 2), 1'b1, 8'h80 + 8'(i)});
    end
    idle(8);
    chk("tput_no_stall", 32'(stall_cnt), 32'(0));
    compare_sb("tput");
    for (int i = 1; i < got_t.size(); i++)
      chk($sformatf("tput_gap%0d", i), 32'(got_t[i] - got_t[i-1]), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
